dm_io_responder: RTL and testbench
==================================

Name: dm_io_responder

Overview:
Memory-mapped I/O responder on the CPU data-memory bus: the target end of the rd_mem/wr_mem/dm_abus/dm_in_dbus/dm_out_dbus interface driven by smpl_cpu2.
- Decodes a 16-word window, containing a down-counting timer and a push/pop FIFO mailbox.
- Sits beside DataMemory2; top-level selects read data with io_hit.
- Reads are combinational, so the single-cycle CPU sees data in the same cycle. Writes and side effects commit on the rising clk edge.

Parameters:
BASE_ADDR, 13'h1FF0, window base; must be 16-word aligned.
FIFO_DEPTH, 8, mailbox entries; power of two, 2..64.
DATA_W, 16, bus data width.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset; sampled on rising clk.
rd_mem  input  1  CPU read strobe, qualified with dm_abus.
wr_mem  input  1  CPU write strobe, qualified with dm_abus.
dm_abus  input  13  CPU data address.
dm_in_dbus  input  16  write data, CPU to memory.
dm_out_dbus  output  16  read data, memory to CPU; 0 when not selected.
io_hit  output  1  dm_abus[12:4]==BASE_ADDR[12:4]; combinational.
irq  output  1  CTRL.IE & STATUS.TEXP.

Behaviour:
- Definitions: sel = io_hit; off = dm_abus[3:0]; wr = sel & wr_mem; rd = sel & rd_mem & ~wr_mem. Write has priority when both strobes are asserted; no read side effect occurs in that case.
- Register map (offset: name, access):
  - 0: CTRL, RW. bit0 TEN timer enable, bit1 ARL auto-reload, bit2 IE irq enable; bits 15:3 read 0.
  - 1: STATUS. bit0 TEXP, sticky, write-1-to-clear. bit1 EMPTY, RO. bit2 FULL, RO. bit3 OVF, sticky, W1C.
  - 2: TLOAD, RW. A write also loads TCOUNT with the written value.
  - 3: TCOUNT, RO.
  - 4: FIFO, W=push, R=pop. Read data is the head entry; the pop commits at the clock edge.
  - 5: FCOUNT, RO, value 0..FIFO_DEPTH.
  - 6-15: reserved; read 0, writes ignored.
- dm_out_dbus = register value when rd, else 16'h0000. Pure combinational from dm_abus/rd_mem/wr_mem and state.
- Reset (reset==0 at edge): CTRL=0, TLOAD=0, TCOUNT=0, TEXP=0, OVF=0, FIFO pointers and count=0. EMPTY reads 1, irq=0.
  - Reset mid-operation discards FIFO contents and any pending write in that cycle.
- Timer, each edge when TEN=1:
  - TCOUNT!=0: TCOUNT<=TCOUNT-1.
  - TCOUNT==0: TEXP<=1. If ARL=1, TCOUNT<=TLOAD and TEN stays 1. If ARL=0, TEN<=0 and TCOUNT stays 0.
  - TLOAD=0 with ARL=1 sets TEXP every cycle.
- Timer priority:
  - A CPU write to TLOAD overrides the timer decrement in that cycle.
  - A CPU write to CTRL overrides the hardware TEN clear.
  - TEXP set and W1C in the same cycle: set wins.
- FIFO: circular buffer with wrap-around pointers mod FIFO_DEPTH.
  - Push when count<DEPTH: store, wptr++, count++.
  - Push when full: data dropped, OVF<=1 (set wins over a same-cycle W1C).
  - Pop when count>0: rptr++, count--.
  - Pop when empty: reads 16'h0000, no state change, no error flag.
  - Push and pop are never simultaneous, because of write priority.
- No wait states; every access completes in the cycle it is presented.

Test Plan:
- Reset: hold reset=0 two cycles, release. Read STATUS -> 16'h0002; read TCOUNT -> 0; read CTRL -> 0; irq=0.
- Decode: read 13'h1FEF -> io_hit=0 and dm_out_dbus=0. Read 13'h1FF5 -> io_hit=1. Write 16'hFFFF to offset 9, then read it -> 0.
- One-shot timer: write TLOAD=3, write CTRL=16'h0005. After 4 edges STATUS.TEXP=1, irq=1, CTRL reads 16'h0004. Write STATUS=16'h0001 -> irq=0.
- Auto-reload: TLOAD=2, CTRL=16'h0003. TEXP sets on cycles 3, 6, 9 relative to enable. A W1C issued on the same cycle as an expiry leaves TEXP=1.
- FIFO: push 16'hA001..16'hA008 -> FCOUNT=8, FULL=1. Push 16'hBEEF -> OVF=1 and FCOUNT stays 8. Pop 8 times -> A001..A008 in order. A ninth pop returns 0 with EMPTY=1.
- Wrap and priority: push 5, pop 5, push 6; pops return correct order across the pointer wrap. rd_mem=wr_mem=1 at FIFO -> push only, dm_out_dbus=0.

Source files
------------

// File: rtl/dm_io_responder.sv
// Memory-mapped I/O responder on the CPU data-memory bus: a 16-word window holding
// a down-counting timer and a push/pop FIFO mailbox. Reads are combinational, writes commit on clk.
module dm_io_responder #(
  parameter logic [12:0] BASE_ADDR  = 13'h1FF0,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DATA_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic [12:0]       dm_abus,
  input  logic [DATA_W-1:0] dm_in_dbus,
  output logic [DATA_W-1:0] dm_out_dbus,
  output logic              io_hit,
  output logic              irq
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [3:0] OFF_CTRL   = 4'd0;
  localparam logic [3:0] OFF_STATUS = 4'd1;
  localparam logic [3:0] OFF_TLOAD  = 4'd2;
  localparam logic [3:0] OFF_TCOUNT = 4'd3;
  localparam logic [3:0] OFF_FIFO   = 4'd4;
  localparam logic [3:0] OFF_FCOUNT = 4'd5;

  logic              ten_q, ten_d, arl_q, arl_d, ie_q, ie_d;
  logic              texp_q, texp_d, ovf_q, ovf_d;
  logic [DATA_W-1:0] tload_q, tload_d, tcount_q, tcount_d;
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     fcnt_q, fcnt_d;
  logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];

  logic       wr, rd, full, empty, push_ok, texp_set, ovf_set, w1c;
  logic [3:0] off;

  assign io_hit = (dm_abus[12:4] == BASE_ADDR[12:4]);
  assign off    = dm_abus[3:0];
  assign wr     = io_hit & wr_mem;
  assign rd     = io_hit & rd_mem & ~wr_mem;
  assign full   = (fcnt_q == FULL_CNT);
  assign empty  = (fcnt_q == '0);
  assign irq    = ie_q & texp_q;

  // Combinational read path so the single-cycle CPU sees data in the same cycle
  always_comb begin
    dm_out_dbus = '0;
    if (rd) begin
      case (off)
        OFF_CTRL:   dm_out_dbus = DATA_W'({ie_q, arl_q, ten_q});
        OFF_STATUS: dm_out_dbus = DATA_W'({ovf_q, full, empty, texp_q});
        OFF_TLOAD:  dm_out_dbus = tload_q;
        OFF_TCOUNT: dm_out_dbus = tcount_q;
        OFF_FIFO:   dm_out_dbus = empty ? '0 : fifo_mem_q[rptr_q];
        OFF_FCOUNT: dm_out_dbus = DATA_W'(fcnt_q);
        default:    dm_out_dbus = '0;
      endcase
    end
  end

  // Next-state: timer first, then CPU writes override it; set beats W1C on sticky flags
  always_comb begin
    ten_d    = ten_q;
    arl_d    = arl_q;
    ie_d     = ie_q;
    tload_d  = tload_q;
    tcount_d = tcount_q;
    texp_d   = texp_q;
    ovf_d    = ovf_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    fcnt_d   = fcnt_q;
    push_ok  = 1'b0;
    texp_set = 1'b0;
    ovf_set  = 1'b0;
    w1c      = wr && (off == OFF_STATUS);

    if (ten_q) begin
      if (tcount_q != '0) begin
        tcount_d = tcount_q - DATA_W'(1);
      end else begin
        texp_set = 1'b1;
        if (arl_q) tcount_d = tload_q;
        else       ten_d    = 1'b0;
      end
    end

    if (wr && (off == OFF_CTRL)) begin
      ten_d = dm_in_dbus[0];
      arl_d = dm_in_dbus[1];
      ie_d  = dm_in_dbus[2];
    end

    if (wr && (off == OFF_TLOAD)) begin
      tload_d  = dm_in_dbus;
      tcount_d = dm_in_dbus;
    end

    if (wr && (off == OFF_FIFO)) begin
      if (!full) begin
        push_ok = 1'b1;
        wptr_d  = wptr_q + PW'(1);
        fcnt_d  = fcnt_q + CW'(1);
      end else begin
        ovf_set = 1'b1;
      end
    end

    if (rd && (off == OFF_FIFO) && !empty) begin
      rptr_d = rptr_q + PW'(1);
      fcnt_d = fcnt_q - CW'(1);
    end

    if (w1c && dm_in_dbus[0]) texp_d = 1'b0;
    if (texp_set)             texp_d = 1'b1;
    if (w1c && dm_in_dbus[3]) ovf_d  = 1'b0;
    if (ovf_set)              ovf_d  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ten_q    <= 1'b0;
      arl_q    <= 1'b0;
      ie_q     <= 1'b0;
      tload_q  <= '0;
      tcount_q <= '0;
      texp_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      fcnt_q   <= '0;
    end else begin
      ten_q    <= ten_d;
      arl_q    <= arl_d;
      ie_q     <= ie_d;
      tload_q  <= tload_d;
      tcount_q <= tcount_d;
      texp_q   <= texp_d;
      ovf_q    <= ovf_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Mailbox storage needs no reset; emptiness is tracked by the count
  always_ff @(posedge clk) begin
    if (reset && push_ok) fifo_mem_q[wptr_q] <= dm_in_dbus;
  end

endmodule

// File: tb/tb_dm_io_responder.sv
// Bench for dm_io_responder: directed scenarios with fixed expectations, then random
// bus traffic checked every cycle against a queue-based behavioural model.
module tb_dm_io_responder;

  localparam int          DEPTH = 8;
  localparam logic [12:0] BASE  = 13'h1FF0;

  logic        clk;
  logic        reset;
  logic        rd_mem;
  logic        wr_mem;
  logic [12:0] dm_abus;
  logic [15:0] dm_in_dbus;
  logic [15:0] dm_out_dbus;
  logic        io_hit;
  logic        irq;

  dm_io_responder #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .DATA_W     (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_mem      (rd_mem),
    .wr_mem      (wr_mem),
    .dm_abus     (dm_abus),
    .dm_in_dbus  (dm_in_dbus),
    .dm_out_dbus (dm_out_dbus),
    .io_hit      (io_hit),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  bit          m_valid = 1'b0;
  bit          m_ten, m_arl, m_ie, m_texp, m_ovf;
  logic [15:0] m_tload, m_tcount;
  logic [15:0] m_fifo [$];

  logic [15:0] obs_out;
  logic        obs_hit, obs_irq;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input bit rd, input bit wr, input logic [12:0] a);
    if (a[12:4] != BASE[12:4] || !rd || wr) return 16'h0000;
    case (a[3:0])
      4'd0:    return {13'h0, m_ie, m_arl, m_ten};
      4'd1:    return {12'h0, m_ovf, (m_fifo.size() == DEPTH), (m_fifo.size() == 0), m_texp};
      4'd2:    return m_tload;
      4'd3:    return m_tcount;
      4'd4:    return (m_fifo.size() > 0) ? m_fifo[0] : 16'h0000;
      4'd5:    return 16'(m_fifo.size());
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit rd, input bit wr,
                            input logic [12:0] a, input logic [15:0] d);
    bit          hit, w, r, set_t, n_ten;
    logic [3:0]  off;
    logic [15:0] n_tcount;
    if (!rst) begin
      m_ten = 0; m_arl = 0; m_ie = 0; m_texp = 0; m_ovf = 0;
      m_tload = 16'h0; m_tcount = 16'h0;
      m_fifo.delete();
      m_valid = 1'b1;
      return;
    end
    hit      = (a[12:4] == BASE[12:4]);
    off      = a[3:0];
    w        = hit && wr;
    r        = hit && rd && !wr;
    set_t    = 1'b0;
    n_ten    = m_ten;
    n_tcount = m_tcount;
    if (m_ten) begin
      if (m_tcount != 16'h0) n_tcount = m_tcount - 16'd1;
      else begin
        set_t = 1'b1;
        if (m_arl) n_tcount = m_tload;
        else       n_ten    = 1'b0;
      end
    end
    if (w && off == 4'd0) begin n_ten = d[0]; m_arl = d[1]; m_ie = d[2]; end
    if (w && off == 4'd2) begin m_tload = d; n_tcount = d; end
    if (w && off == 4'd1) begin
      if (d[0]) m_texp = 1'b0;
      if (d[3]) m_ovf  = 1'b0;
    end
    if (set_t) m_texp = 1'b1;
    if (w && off == 4'd4) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
      else                       m_ovf = 1'b1;
    end
    if (r && off == 4'd4 && m_fifo.size() > 0) void'(m_fifo.pop_front());
    m_ten    = n_ten;
    m_tcount = n_tcount;
  endtask

  // One bus cycle: drive, check combinational outputs against the model, clock, advance model
  task automatic cyc(input bit rst, input bit rd, input bit wr,
                     input logic [12:0] a, input logic [15:0] d);
    @(negedge clk);
    reset      = rst;
    rd_mem     = rd;
    wr_mem     = wr;
    dm_abus    = a;
    dm_in_dbus = d;
    #1;
    obs_out = dm_out_dbus;
    obs_hit = io_hit;
    obs_irq = irq;
    if (m_valid) begin
      chk("hit",   {15'h0, obs_hit}, {15'h0, bit'(a[12:4] == BASE[12:4])});
      chk("rdata", obs_out, model_read(rd, wr, a));
      chk("irq",   {15'h0, obs_irq}, {15'h0, m_ie & m_texp});
    end
    @(posedge clk);
    model_step(rst, rd, wr, a, d);
  endtask

  task automatic wr_reg(input int off, input logic [15:0] d);
    cyc(1'b1, 1'b0, 1'b1, BASE + 13'(off), d);
  endtask

  task automatic rd_reg(input int off, input logic [15:0] exp, input string tag);
    cyc(1'b1, 1'b1, 1'b0, BASE + 13'(off), 16'h0);
    chk(tag, obs_out, exp);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 13'h0000, 16'h0);
  endtask

  initial begin
    logic [12:0] ra;
    logic [15:0] rdat;
    bit          rrst, rrd, rwr;

    reset = 1'b0; rd_mem = 1'b0; wr_mem = 1'b0; dm_abus = 13'h0; dm_in_dbus = 16'h0;

    // Reset
    cyc(1'b0, 1'b0, 1'b0, 13'h0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 13'h0, 16'h0);
    rd_reg(1, 16'h0002, "rst_status");
    chk("rst_irq", {15'h0, obs_irq}, 16'h0000);
    rd_reg(3, 16'h0000, "rst_tcount");
    rd_reg(0, 16'h0000, "rst_ctrl");

    // Decode
    cyc(1'b1, 1'b1, 1'b0, 13'h1FEF, 16'h0);
    chk("dec_miss_hit",  {15'h0, obs_hit}, 16'h0000);
    chk("dec_miss_data", obs_out, 16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 13'h1FF5, 16'h0);
    chk("dec_hit", {15'h0, obs_hit}, 16'h0001);
    wr_reg(9, 16'hFFFF);
    rd_reg(9, 16'h0000, "rsvd_read");

    // One-shot timer
    wr_reg(2, 16'd3);
    wr_reg(0, 16'h0005);
    repeat (4) idle();
    rd_reg(1, 16'h0003, "os_status");
    chk("os_irq", {15'h0, obs_irq}, 16'h0001);
    rd_reg(0, 16'h0004, "os_ctrl");
    wr_reg(1, 16'h0001);
    idle();
    chk("os_irq_clr", {15'h0, obs_irq}, 16'h0000);

    // Auto-reload with a W1C racing an expiry
    wr_reg(2, 16'd2);
    wr_reg(0, 16'h0003);
    idle(); idle(); idle();
    wr_reg(1, 16'h0001);
    rd_reg(1, 16'h0002, "arl_cleared");
    wr_reg(1, 16'h0001);
    rd_reg(1, 16'h0003, "arl_set_wins");
    wr_reg(0, 16'h0000);
    wr_reg(1, 16'h0009);

    // FIFO fill, overflow, drain
    for (int i = 1; i <= 8; i++) wr_reg(4, 16'hA000 + 16'(i));
    rd_reg(5, 16'd8, "fcount_full");
    rd_reg(1, 16'h0004, "status_full");
    wr_reg(4, 16'hBEEF);
    rd_reg(1, 16'h000C, "status_ovf");
    rd_reg(5, 16'd8, "fcount_ovf");
    for (int i = 1; i <= 8; i++) rd_reg(4, 16'hA000 + 16'(i), "pop_order");
    rd_reg(4, 16'h0000, "pop_empty");
    rd_reg(1, 16'h000A, "status_empty");
    wr_reg(1, 16'h0008);

    // Pointer wrap
    for (int i = 1; i <= 5; i++) wr_reg(4, 16'hB000 + 16'(i));
    for (int i = 1; i <= 5; i++) rd_reg(4, 16'hB000 + 16'(i), "wrap_pop_a");
    for (int i = 1; i <= 6; i++) wr_reg(4, 16'hC000 + 16'(i));
    for (int i = 1; i <= 6; i++) rd_reg(4, 16'hC000 + 16'(i), "wrap_pop_b");

    // Simultaneous strobes: push only
    cyc(1'b1, 1'b1, 1'b1, BASE + 13'd4, 16'hD00D);
    chk("dual_out", obs_out, 16'h0000);
    rd_reg(5, 16'd1, "dual_fcount");
    rd_reg(4, 16'hD00D, "dual_pop");

    // Reset mid-operation discards contents and the pending write
    wr_reg(4, 16'h1234);
    cyc(1'b0, 1'b0, 1'b1, BASE + 13'd4, 16'h5678);
    rd_reg(5, 16'd0, "midrst_fcount");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rrst = ($urandom_range(0, 299) != 0);
      ra   = ($urandom_range(0, 9) == 0) ? 13'($urandom) : BASE + 13'($urandom_range(0, 7));
      rrd  = bit'($urandom_range(0, 1));
      rwr  = bit'($urandom_range(0, 1));
      rdat = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
      cyc(rrst, rrd, rwr, ra, rdat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
